// File: rtl/lsu_pkg.sv
// Shared encodings, memory map and helpers for the load/store initiator.
package lsu_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam int         MEM_U_BIT = 2;

  // The instruction region starts at address 0, so only its limit is needed.
  localparam logic [31:0] INSTR_LIMIT = 32'h0000_1FFF;
  localparam logic [31:0] DATA_BASE   = 32'h0000_2000;
  localparam logic [31:0] DATA_LIMIT  = 32'h0000_3FFF;
  localparam logic [31:0] OUTP_BASE   = 32'h0000_7000;
  localparam logic [31:0] OUTP_LIMIT  = 32'h0000_703F;
  localparam logic [31:0] INP_BASE    = 32'h0000_7800;
  localparam logic [31:0] INP_LIMIT   = 32'h0000_781F;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [2:0] {RGN_NONE, RGN_INSTR, RGN_DATA, RGN_OUTP, RGN_INP} region_e;

  function automatic region_e region_of(input logic [31:0] a);
    region_e r;
    r = RGN_NONE;
    if (a <= INSTR_LIMIT)                        r = RGN_INSTR;
    else if (a >= DATA_BASE && a <= DATA_LIMIT)  r = RGN_DATA;
    else if (a >= OUTP_BASE && a <= OUTP_LIMIT)  r = RGN_OUTP;
    else if (a >= INP_BASE && a <= INP_LIMIT)    r = RGN_INP;
    return r;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] op);
    logic [31:0] r;
    case (op[1:0])
      MEM_B:   r = op[MEM_U_BIT] ? {24'h0, raw[7:0]}   : {{24{raw[7]}}, raw[7:0]};
      MEM_H:   r = op[MEM_U_BIT] ? {16'h0, raw[15:0]}  : {{16{raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data onto lanes, load lanes back out with extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] st_wdata,
  input  logic [31:0] ld_word,
  input  logic [1:0]  lane,
  input  logic [2:0]  op,
  output logic [31:0] st_data,
  output logic [31:0] ld_result
);

  logic [31:0] st_masked;
  logic [31:0] ld_shifted;

  always_comb begin
    case (op[1:0])
      MEM_B:   st_masked = {24'h0, st_wdata[7:0]};
      MEM_H:   st_masked = {16'h0, st_wdata[15:0]};
      default: st_masked = st_wdata;
    endcase
    st_data    = st_masked << {lane, 3'b000};
    ld_shifted = ld_word >> {lane, 3'b000};
    ld_result  = extend(ld_shifted, op);
  end

endmodule

// File: rtl/lsu_initiator.sv
// Load/store bus initiator. Optional macro LSU_MISALIGN_SPLIT_EN executes misaligned
// accesses as byte beats instead of faulting them.
module lsu_initiator
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_vld,
  output logic              o_req_rdy,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic              i_req_wren,
  input  logic [2:0]        i_req_op,
  output logic              o_rsp_vld,
  input  logic              i_rsp_rdy,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_lsu_addr,
  output logic [DATA_W-1:0] o_st_data,
  output logic              o_lsu_wren,
  output logic [2:0]        o_mem_op,
  input  logic [DATA_W-1:0] i_ld_data
);

  state_e            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              wren_reg;
  logic              err_reg;
  logic [2:0]        op_reg;

  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_last;
  region_e           rgn_first;
  region_e           rgn_last;
  logic              req_misalign;
  logic              req_access_fault;
  logic              req_fault;

  // Fault check looks at both the first and last byte so wrap-around and region crossings are caught.
  always_comb begin
    req_size     = i_req_op[1:0];
    req_last     = i_req_addr + ((req_size == MEM_W) ? ADDR_W'(3) :
                                 (req_size == MEM_H) ? ADDR_W'(1) : ADDR_W'(0));
    rgn_first    = region_of(i_req_addr);
    rgn_last     = region_of(req_last);
    req_misalign = ((req_size == MEM_H) && i_req_addr[0]) ||
                   ((req_size == MEM_W) && (i_req_addr[1:0] != 2'b00));
    req_access_fault = (req_size == 2'b11) || (rgn_first == RGN_NONE) ||
                       (rgn_last == RGN_NONE) || (rgn_first != rgn_last) ||
                       (i_req_wren && ((rgn_first == RGN_INSTR) || (rgn_first == RGN_INP)));
  end

  logic [1:0]        align_lane;
  logic [2:0]        align_op;
  logic [DATA_W-1:0] align_wdata;
  logic [DATA_W-1:0] st_aligned;
  logic [DATA_W-1:0] ld_result;
  logic [ADDR_W-1:0] bus_addr;
  logic [2:0]        bus_op;
  logic              last_beat;
  logic [DATA_W-1:0] load_result;

  lsu_lane_align u_align (
    .st_wdata  (align_wdata),
    .ld_word   (i_ld_data),
    .lane      (align_lane),
    .op        (align_op),
    .st_data   (st_aligned),
    .ld_result (ld_result)
  );

`ifdef LSU_MISALIGN_SPLIT_EN
  logic              split_reg;
  logic [1:0]        beat_reg;
  logic [DATA_W-1:0] raw_reg;
  logic [DATA_W-1:0] raw_next;
  logic [ADDR_W-1:0] beat_addr;

  assign req_fault = req_access_fault;

  // Split beats reuse the aligner as an unsigned byte access on lane (addr+k)[1:0].
  always_comb begin
    beat_addr   = addr_reg + ADDR_W'(beat_reg);
    align_lane  = split_reg ? beat_addr[1:0] : addr_reg[1:0];
    align_op    = split_reg ? {1'b1, MEM_B} : op_reg;
    align_wdata = split_reg ? (wdata_reg >> {beat_reg, 3'b000}) : wdata_reg;
    bus_addr    = split_reg ? beat_addr : addr_reg;
    bus_op      = split_reg ? 3'b000 : op_reg;
    raw_next    = raw_reg;
    raw_next[{beat_reg, 3'b000} +: 8] = ld_result[7:0];
    last_beat   = !split_reg || (beat_reg == ((op_reg[1:0] == MEM_H) ? 2'd1 : 2'd3));
    load_result = split_reg ? extend(raw_next, op_reg) : ld_result;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      split_reg <= 1'b0;
      beat_reg  <= 2'd0;
      raw_reg   <= '0;
    end else if (state_reg == IDLE && i_req_vld) begin
      split_reg <= req_misalign;
      beat_reg  <= 2'd0;
      raw_reg   <= '0;
    end else if (state_reg == ACCESS) begin
      beat_reg  <= beat_reg + 2'd1;
      raw_reg   <= raw_next;
    end
  end
`else
  assign req_fault = req_access_fault | req_misalign;

  always_comb begin
    align_lane  = addr_reg[1:0];
    align_op    = op_reg;
    align_wdata = wdata_reg;
    bus_addr    = addr_reg;
    bus_op      = op_reg;
    last_beat   = 1'b1;
    load_result = ld_result;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wren_reg  <= 1'b0;
      op_reg    <= 3'b000;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (i_req_vld) begin
          addr_reg  <= i_req_addr;
          wdata_reg <= i_req_wdata;
          wren_reg  <= i_req_wren;
          op_reg    <= i_req_op;
          rdata_reg <= '0;
          err_reg   <= req_fault;
          state_reg <= req_fault ? RESP : ACCESS;
        end
        ACCESS: if (last_beat) begin
          rdata_reg <= wren_reg ? '0 : load_result;
          state_reg <= RESP;
        end
        RESP: if (i_rsp_rdy) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic in_access;
  assign in_access   = (state_reg == ACCESS);
  assign o_req_rdy   = (state_reg == IDLE);
  assign o_rsp_vld   = (state_reg == RESP);
  assign o_rsp_rdata = o_rsp_vld ? rdata_reg : '0;
  assign o_rsp_err   = o_rsp_vld & err_reg;
  assign o_lsu_addr  = in_access ? bus_addr : '0;
  assign o_st_data   = (in_access && wren_reg) ? st_aligned : '0;
  assign o_lsu_wren  = in_access & wren_reg;
  assign o_mem_op    = in_access ? bus_op : 3'b000;

endmodule

// File: tb/tb_lsu_initiator.sv
// Directed bench for lsu_initiator; expectations follow LSU_MISALIGN_SPLIT_EN when defined.
module tb_lsu_initiator;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        i_req_wren;
  logic [2:0]  i_req_op;
  logic        o_rsp_vld;
  logic        i_rsp_rdy;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_lsu_addr;
  logic [31:0] o_st_data;
  logic        o_lsu_wren;
  logic [2:0]  o_mem_op;
  logic [31:0] i_ld_data;

  int n_cmp = 0;
  int n_bad = 0;

  lsu_initiator dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_wren(i_req_wren),
    .i_req_op(i_req_op), .o_rsp_vld(o_rsp_vld), .i_rsp_rdy(i_rsp_rdy),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err), .o_lsu_addr(o_lsu_addr),
    .o_st_data(o_st_data), .o_lsu_wren(o_lsu_wren), .o_mem_op(o_mem_op),
    .i_ld_data(i_ld_data)
  );

  always #5 i_clk = ~i_clk;

  // Two-word responder model: word 0x2000 and "every other word".
  logic [31:0] word0;
  logic [31:0] word1;
  always_comb i_ld_data = (o_lsu_addr[31:2] == 30'h0000_0800) ? word0 : word1;

  int          beat_cnt;
  int          wren_cnt;
  logic [31:0] mon_addr [8];
  logic [31:0] mon_st   [8];
  logic [2:0]  mon_op   [8];

  always @(negedge i_clk) begin
    if (o_lsu_wren) wren_cnt = wren_cnt + 1;
    if (o_lsu_addr != 32'h0 || o_lsu_wren) begin
      if (beat_cnt < 8) begin
        mon_addr[beat_cnt] = o_lsu_addr;
        mon_st[beat_cnt]   = o_st_data;
        mon_op[beat_cnt]   = o_mem_op;
      end
      beat_cnt = beat_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request, waits for the response, optionally holds i_rsp_rdy low for `hold` cycles.
  task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata, input logic wren,
                         input logic [2:0] op, input int hold,
                         output logic [31:0] rdata, output logic err, output int lat);
    @(negedge i_clk);
    check_eq("req_rdy_idle", 32'(o_req_rdy), 32'd1);
    beat_cnt    = 0;
    wren_cnt    = 0;
    i_rsp_rdy   = (hold == 0);
    i_req_vld   = 1'b1;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    i_req_wren  = wren;
    i_req_op    = op;
    @(posedge i_clk);
    #1;
    i_req_vld = 1'b0;
    i_req_addr = 32'h0;
    i_req_wdata = 32'h0;
    i_req_wren = 1'b0;
    i_req_op = 3'b000;
    lat = 1;
    while (!o_rsp_vld && lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    check_eq("rsp_seen", 32'(o_rsp_vld), 32'd1);
    rdata = o_rsp_rdata;
    err   = o_rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge i_clk);
      #1;
      check_eq("bp_vld", 32'(o_rsp_vld), 32'd1);
      check_eq("bp_rdata", o_rsp_rdata, rdata);
      check_eq("bp_req_rdy", 32'(o_req_rdy), 32'd0);
    end
    i_rsp_rdy = 1'b1;
    @(posedge i_clk);
    #1;
    check_eq("post_hs_vld", 32'(o_rsp_vld), 32'd0);
    $display("txn addr=%h wdata=%h wren=%b op=%b -> rdata=%h err=%b lat=%0d beats=%0d",
             addr, wdata, wren, op, rdata, err, lat, beat_cnt);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lt;
  int          vld_seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_req_vld = 1'b0; i_req_addr = 32'h0; i_req_wdata = 32'h0;
    i_req_wren = 1'b0; i_req_op = 3'b000; i_rsp_rdy = 1'b1;
    word0 = 32'h4433_2211; word1 = 32'h8877_6655;
    beat_cnt = 0; wren_cnt = 0;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("rst_req_rdy", 32'(o_req_rdy), 32'd1);
    check_eq("rst_rsp_vld", 32'(o_rsp_vld), 32'd0);
    check_eq("rst_rdata", o_rsp_rdata, 32'h0);
    check_eq("rst_err", 32'(o_rsp_err), 32'd0);
    check_eq("rst_addr", o_lsu_addr, 32'h0);
    check_eq("rst_wren", 32'(o_lsu_wren), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // lw 0x2004
    word1 = 32'hDEAD_BEEF;
    run_req(32'h2004, 32'h0, 1'b0, 3'b010, 0, rd, er, lt);
    check_eq("lw_lat", 32'(lt), 32'd2);
    check_eq("lw_beats", 32'(beat_cnt), 32'd1);
    check_eq("lw_addr", mon_addr[0], 32'h2004);
    check_eq("lw_op", 32'(mon_op[0]), 32'd2);
    check_eq("lw_wren", 32'(wren_cnt), 32'd0);
    check_eq("lw_rdata", rd, 32'hDEAD_BEEF);
    check_eq("lw_err", 32'(er), 32'd0);

    // lb / lbu 0x2007
    word1 = 32'h8012_3456;
    run_req(32'h2007, 32'h0, 1'b0, 3'b000, 0, rd, er, lt);
    check_eq("lb_rdata", rd, 32'hFFFF_FF80);
    check_eq("lb_op", 32'(mon_op[0]), 32'd0);
    run_req(32'h2007, 32'h0, 1'b0, 3'b100, 0, rd, er, lt);
    check_eq("lbu_rdata", rd, 32'h0000_0080);
    check_eq("lbu_op", 32'(mon_op[0]), 32'd4);

    // sh 0x7002
    run_req(32'h7002, 32'h1234_ABCD, 1'b1, 3'b001, 0, rd, er, lt);
    check_eq("sh_beats", 32'(beat_cnt), 32'd1);
    check_eq("sh_addr", mon_addr[0], 32'h7002);
    check_eq("sh_st", mon_st[0], 32'hABCD_0000);
    check_eq("sh_op", 32'(mon_op[0]), 32'd1);
    check_eq("sh_wren", 32'(wren_cnt), 32'd1);
    check_eq("sh_rdata", rd, 32'h0);
    check_eq("sh_err", 32'(er), 32'd0);

    // Faults: sw to instr, lw unmapped, illegal op, lw crossing out of data
    run_req(32'h0100, 32'h5555_5555, 1'b1, 3'b010, 0, rd, er, lt);
    check_eq("f_sw_instr_err", 32'(er), 32'd1);
    check_eq("f_sw_instr_wren", 32'(wren_cnt), 32'd0);
    run_req(32'h5000, 32'h0, 1'b0, 3'b010, 0, rd, er, lt);
    check_eq("f_lw_hole_err", 32'(er), 32'd1);
    check_eq("f_lw_hole_beats", 32'(beat_cnt), 32'd0);
    run_req(32'h2000, 32'h0, 1'b0, 3'b011, 0, rd, er, lt);
    check_eq("f_op11_err", 32'(er), 32'd1);
    check_eq("f_op11_beats", 32'(beat_cnt), 32'd0);
    run_req(32'h3FFE, 32'h0, 1'b0, 3'b010, 0, rd, er, lt);
    check_eq("f_cross_err", 32'(er), 32'd1);
    check_eq("f_cross_beats", 32'(beat_cnt), 32'd0);
    check_eq("f_cross_rdata", rd, 32'h0);

    // Misaligned lw 0x2001
    word0 = 32'h4433_2211; word1 = 32'h8877_6655;
    run_req(32'h2001, 32'h0, 1'b0, 3'b010, 0, rd, er, lt);
`ifdef LSU_MISALIGN_SPLIT_EN
    check_eq("mis_beats", 32'(beat_cnt), 32'd4);
    check_eq("mis_addr0", mon_addr[0], 32'h2001);
    check_eq("mis_addr3", mon_addr[3], 32'h2004);
    check_eq("mis_op", 32'(mon_op[2]), 32'd0);
    check_eq("mis_rdata", rd, 32'h5544_3322);
    check_eq("mis_err", 32'(er), 32'd0);
`else
    check_eq("mis_err", 32'(er), 32'd1);
    check_eq("mis_beats", 32'(beat_cnt), 32'd0);
`endif

    // Backpressure: rsp_rdy low for 3 cycles
    word1 = 32'hDEAD_BEEF;
    run_req(32'h2004, 32'h0, 1'b0, 3'b010, 3, rd, er, lt);
    check_eq("bp_final_rdata", rd, 32'hDEAD_BEEF);
    check_eq("bp_final_req_rdy", 32'(o_req_rdy), 32'd1);

    // Reset in the middle of a store
    @(negedge i_clk);
    beat_cnt = 0; wren_cnt = 0;
    i_req_vld = 1'b1; i_req_wren = 1'b1; i_req_wdata = 32'h1122_3344; i_req_op = 3'b010;
`ifdef LSU_MISALIGN_SPLIT_EN
    i_req_addr = 32'h7001;
`else
    i_req_addr = 32'h2008;
`endif
    @(posedge i_clk);
    #1;
    i_req_vld = 1'b0;
    @(negedge i_clk);
`ifdef LSU_MISALIGN_SPLIT_EN
    @(negedge i_clk);
    check_eq("rst_mid_addr", o_lsu_addr, 32'h7002);
    check_eq("rst_mid_st", o_st_data, 32'h0033_0000);
`else
    check_eq("rst_mid_addr", o_lsu_addr, 32'h2008);
    check_eq("rst_mid_st", o_st_data, 32'h1122_3344);
`endif
    check_eq("rst_mid_wren_pre", 32'(o_lsu_wren), 32'd1);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    check_eq("rst_mid_wren", 32'(o_lsu_wren), 32'd0);
    check_eq("rst_mid_req_rdy", 32'(o_req_rdy), 32'd1);
    @(negedge i_clk);
    i_rst = 1'b0;
    vld_seen = 0;
    repeat (4) begin
      @(posedge i_clk);
      #1;
      if (o_rsp_vld) vld_seen++;
    end
    check_eq("rst_mid_no_rsp", 32'(vld_seen), 32'd0);
`ifdef LSU_MISALIGN_SPLIT_EN
    check_eq("rst_mid_wren_cnt", 32'(wren_cnt), 32'd2);
`else
    check_eq("rst_mid_wren_cnt", 32'(wren_cnt), 32'd1);
`endif
    $display("txn reset-abort store -> wren_cycles=%0d", wren_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_initiator.md
Name: lsu_initiator

Overview:
- Pipeline-side master for the memory-mapped load/store responder (instr 0x0000–0x1FFF, data 0x2000–0x3FFF, output peripherals 0x7000–0x703F, input peripherals 0x7800–0x781F).
- Accepts one load/store request at a time over a valid/ready handshake.
- Checks the access for faults, moves store data onto the correct byte lanes and drives the responder's addr/st_data/wren/mem_op bus.
- For loads, extracts the addressed lanes from the returned word and sign- or zero-extends them. The result is returned on a held response handshake.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_vld  in  1  request valid.
- o_req_rdy  out  1  high only in IDLE.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-justified.
- i_req_wren  in  1  1 = store, 0 = load.
- i_req_op  in  3  [1:0]: 00 byte, 01 half, 10 word, 11 illegal; [2]: 1 = unsigned load.
- o_rsp_vld  out  1  response valid, held until accepted.
- i_rsp_rdy  in  1  response accept.
- o_rsp_rdata  out  32  extended load data; 0 for stores and faults.
- o_rsp_err  out  1  misaligned, illegal-op or access fault.
- o_lsu_addr  out  32  bus address.
- o_st_data  out  32  lane-aligned store data.
- o_lsu_wren  out  1  bus write enable.
- o_mem_op  out  3  bus size/sign code.
- i_ld_data  in  32  bus read word, combinational, same cycle.

Behaviour:
- Reset: the block is in IDLE and drives o_req_rdy=1. All other outputs are 0.
- Reset mid-operation: abandons the transaction. Bus wren is 0 from the next cycle on. No response is issued.
- FSM: IDLE -> ACCESS -> RESP -> IDLE. IDLE can also go directly to RESP on an error.
- Accept: on i_req_vld & o_req_rdy in IDLE, the request is registered.
  - If an error is detected, go to RESP with err=1 and issue no bus beat.
  - Otherwise go to ACCESS.
- ACCESS: one bus beat per cycle.
  - Bus outputs are driven from registered state; o_lsu_wren = stored wren.
  - i_ld_data is sampled at the end of each beat.
  - After the last beat, go to RESP.
  - Outside ACCESS the bus outputs are all 0.
- Aligned access:
  - One beat: o_lsu_addr = req addr, o_mem_op = req op.
  - o_st_data = wdata shifted left by 8*addr[1:0] (half: 16*addr[1]).
  - Load result = lanes selected by addr[1:0], extended by op[2].
  - Latency: accept at cycle T, beat at T+1, o_rsp_vld at T+2.
- Misalignment: half with addr[0]=1, or word with addr[1:0]≠0.
- Faults (err=1, no beat):
  - op[1:0]=11.
  - First or last byte address outside every region.
  - First and last byte in different regions.
  - Store to the instruction region.
  - Store to the input peripheral region.
- RESP:
  - o_rsp_vld=1, with rdata and err held stable until i_rsp_rdy.
  - On handshake, return to IDLE. o_req_rdy rises the cycle after the handshake; there is no same-cycle re-accept.
- Address arithmetic: 32-bit, wraps modulo 2^32. The fault check catches wrap-around.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: a misaligned access is executed as N byte beats, with N=2 for half and N=4 for word.
  - Beat k address = addr+k, mem_op=000.
  - st_data = wdata[8k+:8] placed on lane (addr+k)[1:0].
  - For loads, byte k is taken from lane (addr+k)[1:0] into raw[8k+:8]. Extension is applied to the assembled value.
  - Faults are still checked before the first beat.
- Undefined: a misaligned access produces err=1 with no bus beat.

Decomposition:
- Package lsu_pkg:
  - mem_op encodings (MEM_B, MEM_H, MEM_W, unsigned bit).
  - Region base/limit constants.
  - The state enum {IDLE, ACCESS, RESP}.
  - Region-decode function.
- One sub-module, lsu_lane_align (combinational):
  - Store lane shift.
  - Load lane extract plus sign/zero extension.
  - Reused by both aligned and split paths.

Test Plan:
- Aligned load: lw 0x2004 with i_ld_data=0xDEADBEEF -> one beat (addr 0x2004, mem_op 010, wren 0); rsp_vld at T+2, rdata 0xDEADBEEF, err 0.
- Byte extension: lb 0x2007 with i_ld_data=0x80123456 -> rdata 0xFFFFFF80; lbu at the same address -> 0x00000080.
- Half store: sh 0x7002, wdata 0x1234ABCD -> o_st_data 0xABCD0000, mem_op 001, wren 1 for exactly one cycle; rsp rdata 0, err 0.
- Faults, each giving err=1 and wren never asserted:
  - sw 0x0100.
  - lw 0x5000.
  - op 011.
  - lw 0x3FFE with the split macro defined, because it crosses out of the data region.
- Misaligned lw 0x2001, memory word 0x2000=0x44332211 and word 0x2004=0x88776655:
  - Split macro defined -> 4 beats at 0x2001–0x2004, rdata 0x55443322.
  - Split macro undefined -> err 1, no beat.
- Backpressure and reset:
  - Hold i_rsp_rdy=0 for 3 cycles -> rsp stable, req_rdy 0.
  - Assert i_rst during beat 2 of a split store -> no further wren, IDLE next cycle, no rsp_vld.
